// File: rtl/toggle_req_tx.sv
// Source side of a two-phase toggle handshake: accepts a word, flips tx_tgl and
// holds tx_data until the resynchronised ack toggle catches up with tx_tgl.
module toggle_req_tx #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              resetb,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              tx_tgl,
  output logic [DATA_W-1:0] tx_data,
  input  logic              ack_tgl_sync,
  output logic              busy,
  output logic [CNT_W-1:0]  xfer_cnt,
  output logic              timeout_err,
  input  logic              err_clr
);

  localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_SAT = TMR_W'(TIMEOUT);
  localparam logic [TMR_W-1:0] TMR_THR = TMR_W'(TIMEOUT - 1);

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_ACK = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic               tx_tgl_q, tx_tgl_d;
  logic [DATA_W-1:0]  tx_data_q, tx_data_d;
  logic [CNT_W-1:0]   xfer_cnt_q, xfer_cnt_d;
  logic               timeout_err_q, timeout_err_d;
  logic [TMR_W-1:0]   timer_q, timer_d;

  logic accept;
  logic ack;
  logic hit_thr;

  // An ack that coincides with the threshold edge completes the transfer and suppresses the error.
  assign accept  = (state_q == IDLE) && in_valid;
  assign ack     = (state_q == WAIT_ACK) && (ack_tgl_sync == tx_tgl_q);
  assign hit_thr = (state_q == WAIT_ACK) && !ack && (timer_q == TMR_THR);

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (ack) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state_q == IDLE);
    busy     = (state_q == WAIT_ACK);
  end

  always_comb begin
    tx_tgl_d      = tx_tgl_q;
    tx_data_d     = tx_data_q;
    xfer_cnt_d    = xfer_cnt_q;
    timeout_err_d = timeout_err_q;
    timer_d       = timer_q;

    if (accept) begin
      tx_data_d = in_data;
      tx_tgl_d  = ~tx_tgl_q;
      timer_d   = '0;
    end

    if (ack) begin
      xfer_cnt_d = xfer_cnt_q + 1'b1;
    end else if ((state_q == WAIT_ACK) && (timer_q != TMR_SAT)) begin
      timer_d = timer_q + 1'b1;
    end

    // A new timeout outranks a simultaneous clear so no error event is lost.
    if (hit_thr) begin
      timeout_err_d = 1'b1;
    end else if (err_clr) begin
      timeout_err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      tx_tgl_q      <= 1'b0;
      tx_data_q     <= '0;
      xfer_cnt_q    <= '0;
      timeout_err_q <= 1'b0;
      timer_q       <= '0;
    end else begin
      tx_tgl_q      <= tx_tgl_d;
      tx_data_q     <= tx_data_d;
      xfer_cnt_q    <= xfer_cnt_d;
      timeout_err_q <= timeout_err_d;
      timer_q       <= timer_d;
    end
  end

  assign tx_tgl      = tx_tgl_q;
  assign tx_data     = tx_data_q;
  assign xfer_cnt    = xfer_cnt_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_toggle_req_tx.sv
// Bench for toggle_req_tx: accepted words are queued with their expected
// completion count and checked when the DUT leaves WAIT_ACK.
module tb_toggle_req_tx;

  logic       clk = 1'b0;
  logic       resetb;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       tx_tgl;
  logic [7:0] tx_data;
  logic       ack_tgl_sync;
  logic       busy;
  logic [1:0] xfer_cnt;
  logic       timeout_err;
  logic       err_clr;

  logic       loopback;
  logic       ack_drv;

  typedef struct {
    logic [7:0] data;
    logic [1:0] cnt;
  } sb_t;

  sb_t        sb_q[$];
  sb_t        mon_e;
  logic       prev_busy = 1'b0;
  logic       exp_tgl;
  logic [1:0] exp_cnt;
  int         vectors = 0;
  int         miscompares = 0;
  logic [7:0] words [3] = '{8'h11, 8'h22, 8'h33};

  always #5 clk = ~clk;

  assign ack_tgl_sync = loopback ? tx_tgl : ack_drv;

  toggle_req_tx #(
    .DATA_W (8),
    .CNT_W  (2),
    .TIMEOUT(8)
  ) dut (
    .clk         (clk),
    .resetb      (resetb),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .tx_tgl      (tx_tgl),
    .tx_data     (tx_data),
    .ack_tgl_sync(ack_tgl_sync),
    .busy        (busy),
    .xfer_cnt    (xfer_cnt),
    .timeout_err (timeout_err),
    .err_clr     (err_clr)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept one word on the next edge; hold keeps in_valid high afterwards.
  task automatic applyStimulus(input logic [7:0] d, input bit hold);
    sb_t e;
    in_valid = 1'b1;
    in_data  = d;
    checkOutput("accept_ready", in_ready, 1);
    tick();
    if (!hold) in_valid = 1'b0;
    exp_tgl = ~exp_tgl;
    e.data  = d;
    e.cnt   = exp_cnt + 2'd1;
    sb_q.push_back(e);
    checkOutput("accept_tgl", tx_tgl, exp_tgl);
    checkOutput("accept_data", tx_data, d);
    checkOutput("accept_busy", busy, 1);
    checkOutput("accept_not_ready", in_ready, 0);
  endtask

  // Completion monitor: a WAIT_ACK -> IDLE transition outside reset retires one entry.
  always @(posedge clk) begin
    #2;
    if (resetb && prev_busy && !busy) begin
      checkOutput("sb_pending", sb_q.size() != 0, 1);
      if (sb_q.size() != 0) begin
        mon_e = sb_q.pop_front();
        checkOutput("done_data", tx_data, mon_e.data);
        checkOutput("done_cnt", xfer_cnt, mon_e.cnt);
        checkOutput("done_ready", in_ready, 1);
        exp_cnt = mon_e.cnt;
      end
    end
    prev_busy = busy;
  end

  initial begin
    resetb   = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    err_clr  = 1'b0;
    loopback = 1'b0;
    ack_drv  = 1'b0;
    exp_tgl  = 1'b0;
    exp_cnt  = 2'd0;

    repeat (2) tick();
    checkOutput("rst_ready", in_ready, 1);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_tgl", tx_tgl, 0);
    checkOutput("rst_data", tx_data, 0);
    checkOutput("rst_cnt", xfer_cnt, 0);
    checkOutput("rst_err", timeout_err, 0);
    resetb = 1'b1;
    tick();
    checkOutput("post_rst_ready", in_ready, 1);
    checkOutput("post_rst_busy", busy, 0);

    // Loopback streaming, in_valid held high
    loopback = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(words[i], 1'b1);
      tick();
      checkOutput("stream_busy", busy, 0);
      checkOutput("stream_tgl_hold", tx_tgl, exp_tgl);
      checkOutput("stream_data_hold", tx_data, words[i]);
    end
    in_valid = 1'b0;
    ack_drv  = exp_tgl;
    loopback = 1'b0;
    tick();
    checkOutput("stream_cnt", xfer_cnt, 3);

    // Delayed ack: sampled six edges after accept
    applyStimulus(8'hA5, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      tick();
      checkOutput("dly_ready", in_ready, 0);
      checkOutput("dly_data", tx_data, 8'hA5);
      checkOutput("dly_err", timeout_err, 0);
    end
    ack_drv = exp_tgl;
    tick();
    checkOutput("dly_done_ready", in_ready, 1);
    checkOutput("dly_done_busy", busy, 0);
    checkOutput("dly_done_err", timeout_err, 0);

    // Timeout with no ack
    applyStimulus(8'h3C, 1'b0);
    for (int k = 1; k <= 7; k++) begin
      tick();
      checkOutput("to_early_err", timeout_err, 0);
      checkOutput("to_early_busy", busy, 1);
    end
    tick();
    checkOutput("to_rise_err", timeout_err, 1);
    checkOutput("to_rise_busy", busy, 1);
    repeat (3) begin
      tick();
      checkOutput("to_hold_err", timeout_err, 1);
      checkOutput("to_hold_busy", busy, 1);
      checkOutput("to_hold_data", tx_data, 8'h3C);
    end
    ack_drv = exp_tgl;
    tick();
    checkOutput("late_ack_busy", busy, 0);
    checkOutput("late_ack_err", timeout_err, 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checkOutput("clr_err", timeout_err, 0);

    // Set and clear on the same edge
    applyStimulus(8'h5A, 1'b0);
    for (int k = 1; k <= 7; k++) begin
      tick();
      checkOutput("sc_early_err", timeout_err, 0);
    end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checkOutput("set_wins_err", timeout_err, 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checkOutput("clr_only_err", timeout_err, 0);
    checkOutput("clr_only_busy", busy, 1);
    repeat (2) begin
      tick();
      checkOutput("sat_no_refire", timeout_err, 0);
    end
    ack_drv = exp_tgl;
    tick();
    checkOutput("sc_done_busy", busy, 0);

    // Ack on the threshold edge
    applyStimulus(8'h77, 1'b0);
    for (int k = 1; k <= 7; k++) begin
      tick();
      checkOutput("thr_early_err", timeout_err, 0);
    end
    ack_drv = exp_tgl;
    tick();
    checkOutput("thr_ack_err", timeout_err, 0);
    checkOutput("thr_ack_busy", busy, 0);

    // Reset mid-transfer
    resetb  = 1'b0;
    sb_q.delete();
    exp_cnt = 2'd0;
    exp_tgl = 1'b0;
    ack_drv = 1'b0;
    repeat (2) tick();
    resetb = 1'b1;
    tick();
    applyStimulus(8'h99, 1'b0);
    tick();
    checkOutput("mid_busy_pre", busy, 1);
    resetb = 1'b0;
    sb_q.delete();
    exp_tgl = 1'b0;
    exp_cnt = 2'd0;
    #1;
    checkOutput("mid_rst_busy", busy, 0);
    checkOutput("mid_rst_ready", in_ready, 1);
    checkOutput("mid_rst_tgl", tx_tgl, 0);
    checkOutput("mid_rst_cnt", xfer_cnt, 0);
    repeat (2) tick();
    resetb = 1'b1;
    tick();
    checkOutput("mid_post_cnt", xfer_cnt, 0);
    checkOutput("mid_post_ready", in_ready, 1);

    // Counter wrap with CNT_W=2
    loopback = 1'b1;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(8'(8'h40 + i), 1'b1);
      tick();
      checkOutput("wrap_busy", busy, 0);
    end
    in_valid = 1'b0;
    ack_drv  = exp_tgl;
    loopback = 1'b0;
    tick();
    checkOutput("wrap_cnt", xfer_cnt, 1);

    // Spurious ack edge in IDLE
    ack_drv = ~exp_tgl;
    repeat (3) begin
      tick();
      checkOutput("spur_busy", busy, 0);
      checkOutput("spur_ready", in_ready, 1);
      checkOutput("spur_tgl", tx_tgl, exp_tgl);
      checkOutput("spur_cnt", xfer_cnt, 1);
    end
    ack_drv = exp_tgl;
    tick();
    checkOutput("sb_drain", sb_q.size(), 0);
    #5;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/toggle_req_tx.md
# toggle_req_tx

Source-side transmitter of the two-phase toggle handshake. It accepts a data word over a valid/ready interface and flips `tx_tgl`, which the destination domain samples through `dff_sync`. It holds `tx_data` stable until the destination's ack toggle, already resynchronised into `clk` by a `dff_sync` instance, matches `tx_tgl`. It also counts completed transfers and flags acks that do not arrive within a bounded time.

## Interface
- `DATA_W`, 8, width of the transferred word.
- `CNT_W`, 8, width of the completed-transfer counter.
- `TIMEOUT`, 64, cycles in WAIT_ACK without an ack before `timeout_err` sets; legal range ≥ 2.
- `clk`  in  1  source-domain clock.
- `resetb`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  upstream word valid.
- `in_ready`  out  1  block can accept a word this cycle.
- `in_data`  in  `DATA_W`  upstream word.
- `tx_tgl`  out  1  request toggle to the destination `dff_sync`.
- `tx_data`  out  `DATA_W`  bundled data; stable while a request is outstanding.
- `ack_tgl_sync`  in  1  destination ack toggle, already synchronised to `clk`.
- `busy`  out  1  request outstanding (state WAIT_ACK).
- `xfer_cnt`  out  `CNT_W`  completed transfers, wraps modulo 2^`CNT_W`.
- `timeout_err`  out  1  sticky ack-timeout flag.
- `err_clr`  in  1  synchronous clear of `timeout_err`.

## Operation
- Two states, both registered:
  - IDLE: `in_ready`=1, `busy`=0.
  - WAIT_ACK: `in_ready`=0, `busy`=1.
- `in_ready` and `busy` are decoded from the state register only; they have no combinational path from inputs.
- IDLE with `in_valid`=1 (accept):
  - `tx_data` <= `in_data`.
  - `tx_tgl` <= ~`tx_tgl`.
  - timer <= 0.
  - Next state WAIT_ACK.
- IDLE with `in_valid`=0: no change.
- WAIT_ACK, ack condition:
  - Ack is `ack_tgl_sync` == `tx_tgl`, compared combinationally each cycle.
  - On ack: next state IDLE; `xfer_cnt` <= `xfer_cnt`+1, wrapping.
- WAIT_ACK, no ack:
  - timer increments, saturating at `TIMEOUT`. Timer width is clog2(`TIMEOUT`+1).
  - When timer == `TIMEOUT`-1 and there is no ack, `timeout_err` <= 1.
  - The block keeps waiting; it never abandons or retransmits a request.
- `tx_data` and `tx_tgl` change only on accept.
- `timeout_err`:
  - Cleared by `err_clr`=1.
  - If set and clear occur in the same cycle, set wins.
  - `err_clr` has no other effect.
- Ack and timeout threshold in the same cycle: ack wins, no error.
- In IDLE, `ack_tgl_sync` != `tx_tgl` (spurious ack edge) is ignored.
- Reset values:
  - State IDLE, so `in_ready`=1 and `busy`=0.
  - `tx_tgl`=0, `tx_data`=0, `xfer_cnt`=0, `timeout_err`=0, timer=0.
- Reset mid-transfer:
  - Asserting `resetb` in WAIT_ACK returns the block to IDLE with `tx_tgl`=0; the outstanding transfer is dropped and not counted.
  - The destination side must share the same reset so that its ack toggle also returns to 0.

## Timing
- Accept at edge N:
  - `tx_tgl` and `tx_data` update after edge N.
  - `in_ready` is 0 from edge N until the cycle after ack.
- Ack sampled at edge M (M ≥ N+1): IDLE and `in_ready`=1 after M; `xfer_cnt` increments at M.
- Minimum transfer period with a direct loopback (`ack_tgl_sync`=`tx_tgl`): 2 cycles per word.
- The system round trip adds the destination `dff_sync` (2–3 destination cycles) plus ack synchronisation (2–3 `clk` cycles).
- `timeout_err` rises at edge N+`TIMEOUT` when no ack has been sampled at edges N+1 … N+`TIMEOUT`.

## Test plan
- **Reset:** hold `resetb`=0, then release. Required: `in_ready`=1, `busy`=0, `tx_tgl`=0, `tx_data`=0, `xfer_cnt`=0, `timeout_err`=0.
- **Loopback streaming:** tie `ack_tgl_sync`=`tx_tgl`; drive words 0x11, 0x22, 0x33 with `in_valid` held high. Required:
  - `tx_tgl` toggles every 2 cycles.
  - `tx_data` is 0x11, 0x22, 0x33, each held 2 cycles.
  - `xfer_cnt`=3.
- **Delayed ack:** accept 0xA5, then echo `tx_tgl` back after 5 cycles. Required:
  - `tx_data`=0xA5 stable throughout.
  - `in_ready`=0 for 6 cycles.
  - `timeout_err`=0.
  - Then return to IDLE with `xfer_cnt`+1.
- **Timeout:** with `TIMEOUT`=8, accept a word and never ack. Required:
  - `timeout_err` rises exactly 8 edges after accept; `busy` stays 1.
  - A late ack then completes the transfer normally.
  - `err_clr` asserted together with a set edge leaves `timeout_err`=1; `err_clr` alone then clears it.
- **Wrap and spurious ack:**
  - With `CNT_W`=2, run 5 transfers. Required: `xfer_cnt`=1.
  - In IDLE, flip `ack_tgl_sync`. Required: no state change, no count.
- **Reset mid-transfer:** accept a word (`tx_tgl`=1), assert `resetb` while in WAIT_ACK. Required: IDLE, `tx_tgl`=0, `xfer_cnt` unchanged from its reset value of 0.
